fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/eq_pkg.sv | 13 +
 rtl/fir_seq_ctrl.sv | 117 +++++++++++
 tb/tb_fir_seq_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the FIR sequencing controller:
// the FSM state encoding and the tap count loaded at reset.
package eq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEQ     = 2'd1,
        ST_CAPTURE = 2'd2
    } seq_state_e;

    localparam int DEF_TAPS = 1021;

endpackage

// File: rtl/fir_seq_ctrl.sv
// Sequencer for the FIR bands: strobes seq for taps+1 cycles per sample,
// captures the band results, and queues at most one sample that arrives early.
module fir_seq_ctrl #(
    parameter int TAPS_W   = 10,
    parameter int DEF_TAPS = eq_pkg::DEF_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld,
    input  logic [TAPS_W-1:0] taps,
    input  logic              abort,
    input  logic              ovr_clr,
    input  logic [15:0]       fir_lft,
    input  logic [15:0]       fir_rght,
    output logic              seq,
    output logic [15:0]       lft_out,
    output logic [15:0]       rght_out,
    output logic              out_vld,
    output logic              busy,
    output logic              overrun
);

    import eq_pkg::*;

    seq_state_e        state_q;
    logic [TAPS_W-1:0] cnt_q;
    logic [TAPS_W-1:0] tap_q;
    logic              pending_q;
    logic              overrun_q;
    logic [15:0]       lft_q;
    logic [15:0]       rght_q;
    logic              out_vld_q;

    logic [TAPS_W-1:0] cnt_d;
    logic              drop_d;
    logic              overrun_d;

    assign cnt_d = cnt_q + TAPS_W'(1);

    // A sample is dropped when one is already queued and another arrives while busy.
    always_comb begin
        drop_d = 1'b0;
        if (vld && !abort && pending_q &&
            (state_q == ST_SEQ || state_q == ST_CAPTURE)) begin
            drop_d = 1'b1;
        end
    end

    // Setting wins over a simultaneous clear.
    assign overrun_d = drop_d | (overrun_q & ~ovr_clr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tap_q     <= TAPS_W'(DEF_TAPS);
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            lft_q     <= '0;
            rght_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= 1'b0;
            overrun_q <= overrun_d;
            if (abort) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                pending_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (vld) begin
                            state_q <= ST_SEQ;
                            tap_q   <= taps;
                            cnt_q   <= '0;
                        end
                    end
                    ST_SEQ: begin
                        if (vld && !pending_q) begin
                            pending_q <= 1'b1;
                        end
                        if (cnt_q == tap_q) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    ST_CAPTURE: begin
                        lft_q     <= fir_lft;
                        rght_q    <= fir_rght;
                        out_vld_q <= 1'b1;
                        // A queued or freshly arriving sample restarts sequencing back-to-back.
                        if (pending_q || vld) begin
                            state_q   <= ST_SEQ;
                            tap_q     <= taps;
                            cnt_q     <= '0;
                            pending_q <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign seq      = (state_q == ST_SEQ);
    assign busy     = (state_q != ST_IDLE);
    assign lft_out  = lft_q;
    assign rght_out = rght_q;
    assign out_vld  = out_vld_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed scenarios plus randomized traffic for fir_seq_ctrl, checked every
// cycle against a sample-level model (remaining-cycle budget and a pending queue).
module tb_fir_seq_ctrl;

    localparam int TAPS_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              vld;
    logic [TAPS_W-1:0] taps;
    logic              abort;
    logic              ovr_clr;
    logic [15:0]       fir_lft;
    logic [15:0]       fir_rght;
    logic              seq;
    logic [15:0]       lft_out;
    logic [15:0]       rght_out;
    logic              out_vld;
    logic              busy;
    logic              overrun;

    always #5 clk = ~clk;

    fir_seq_ctrl #(.TAPS_W(TAPS_W), .DEF_TAPS(1021)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld),
        .taps     (taps),
        .abort    (abort),
        .ovr_clr  (ovr_clr),
        .fir_lft  (fir_lft),
        .fir_rght (fir_rght),
        .seq      (seq),
        .lft_out  (lft_out),
        .rght_out (rght_out),
        .out_vld  (out_vld),
        .busy     (busy),
        .overrun  (overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: cycles left in the current sample (seq cycles + 1 capture), queued samples.
    int          m_rem  = 0;
    int          m_pend = 0;
    bit          m_ovr  = 1'b0;
    bit          m_ovld = 1'b0;
    logic [15:0] m_l    = '0;
    logic [15:0] m_r    = '0;

    int seq_hi  = 0;
    int ovld_n  = 0;
    int busy_n  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit drop;
        drop = 1'b0;
        if (!rst_n) begin
            m_rem = 0; m_pend = 0; m_ovr = 1'b0; m_ovld = 1'b0; m_l = '0; m_r = '0;
            return;
        end
        m_ovld = 1'b0;
        if (abort) begin
            m_rem  = 0;
            m_pend = 0;
        end else if (m_rem == 0) begin
            if (vld) m_rem = int'(taps) + 2;
        end else if (m_rem >= 2) begin
            if (vld) begin
                if (m_pend == 1) drop = 1'b1;
                else m_pend = 1;
            end
            m_rem--;
        end else begin
            m_l    = fir_lft;
            m_r    = fir_rght;
            m_ovld = 1'b1;
            if (m_pend == 1 || vld) begin
                if (m_pend == 1 && vld) drop = 1'b1;
                m_pend = 0;
                m_rem  = int'(taps) + 2;
            end else begin
                m_rem = 0;
            end
        end
        m_ovr = drop ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("seq",      32'(seq),      32'(m_rem >= 2));
        chk("busy",     32'(busy),     32'(m_rem != 0));
        chk("out_vld",  32'(out_vld),  32'(m_ovld));
        chk("overrun",  32'(overrun),  32'(m_ovr));
        chk("lft_out",  32'(lft_out),  32'(m_l));
        chk("rght_out", 32'(rght_out), 32'(m_r));
        if (seq)     seq_hi++;
        if (out_vld) ovld_n++;
        if (busy)    busy_n++;
        $display("[TB] t=%0t vld=%0b taps=%0d abort=%0b seq=%0b busy=%0b out_vld=%0b ovr=%0b lft=%04h",
                 $time, vld, taps, abort, seq, busy, out_vld, overrun, lft_out);
        fir_lft  = 16'($urandom);
        fir_rght = 16'($urandom);
    endtask

    task automatic clr_tally();
        seq_hi = 0; ovld_n = 0; busy_n = 0;
    endtask

    task automatic drain();
        vld = 1'b0; abort = 1'b0; ovr_clr = 1'b0;
        for (int i = 0; i < 1100 && m_rem != 0; i++) step();
        step();
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; taps = '0; abort = 1'b0; ovr_clr = 1'b0;
        fir_lft = 16'h1234; fir_rght = 16'h5678;
        step(); step();
        rst_n = 1'b1;
        step();

        // taps=4: five seq cycles, one out_vld
        clr_tally();
        taps = 10'd4; vld = 1'b1; step();
        vld = 1'b0;
        repeat (8) step();
        chk("r31_seq_cycles", 32'(seq_hi), 32'd5);
        chk("r31_out_vld_n",  32'(ovld_n), 32'd1);

        // taps=0: one seq cycle, busy for two
        clr_tally();
        taps = 10'd0; vld = 1'b1; step();
        vld = 1'b0;
        repeat (4) step();
        chk("r32_seq_cycles", 32'(seq_hi), 32'd1);
        chk("r32_busy_cycles", 32'(busy_n), 32'd2);
        chk("r32_out_vld_n",  32'(ovld_n), 32'd1);

        // back-to-back via pending, no overrun
        clr_tally();
        taps = 10'd4; vld = 1'b1; step();
        vld = 1'b0; step(); step();
        vld = 1'b1; step();
        vld = 1'b0;
        repeat (14) step();
        chk("r33_seq_cycles", 32'(seq_hi), 32'd10);
        chk("r33_busy_cycles", 32'(busy_n), 32'd12);
        chk("r33_out_vld_n",  32'(ovld_n), 32'd2);
        chk("r33_overrun",    32'(overrun), 32'd0);

        // third vld overflows the pending slot
        clr_tally();
        taps = 10'd4; vld = 1'b1; step();
        vld = 1'b0; step(); step();
        vld = 1'b1; step();
        vld = 1'b1; step();
        vld = 1'b0;
        repeat (14) step();
        chk("r33b_out_vld_n", 32'(ovld_n), 32'd2);
        chk("r33b_overrun",   32'(overrun), 32'd1);

        // drop coinciding with ovr_clr keeps overrun set; clear alone then works
        taps = 10'd4; vld = 1'b1; step();
        step();
        ovr_clr = 1'b1; step();
        chk("r35_overrun_held", 32'(overrun), 32'd1);
        vld = 1'b0; step();
        chk("r35_overrun_clr", 32'(overrun), 32'd0);
        ovr_clr = 1'b0;
        drain();

        // abort with vld in a long run
        clr_tally();
        taps = 10'd1021; vld = 1'b1; step();
        vld = 1'b0; step(); step();
        abort = 1'b1; vld = 1'b1; step();
        abort = 1'b0; vld = 1'b0;
        chk("r34_busy", 32'(busy), 32'd0);
        repeat (5) step();
        chk("r34_out_vld_n", 32'(ovld_n), 32'd0);
        chk("r34_busy_after", 32'(busy), 32'd0);

        // reset mid-SEQ
        taps = 10'd4; vld = 1'b1; step();
        vld = 1'b0; step(); step();
        rst_n = 1'b0; step();
        chk("r36_seq", 32'(seq), 32'd0);
        chk("r36_lft", 32'(lft_out), 32'd0);
        rst_n = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            vld     = ($urandom_range(0, 3) == 0);
            taps    = TAPS_W'($urandom_range(0, 9));
            abort   = ($urandom_range(0, 79) == 0);
            ovr_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        rst_n = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
